// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
// Shares one port of a split-mode 18K BRAM half among NUM_REQ requesters.
// Round-robin grant, one access per cycle, valid/ready on the request side and
// a one-hot read response one cycle after acceptance. An optional clear
// sequencer zero-fills the whole array after reset before any grant is given.

module bram_port_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ABITS          = 10,
    parameter int DBITS          = 18,
    parameter int BE_WIDTH       = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_REQ-1:0]          REQ_VALID,
    output logic [NUM_REQ-1:0]          REQ_READY,
    input  logic [NUM_REQ-1:0]          REQ_WE,
    input  logic [NUM_REQ*ABITS-1:0]    REQ_ADDR,
    input  logic [NUM_REQ*DBITS-1:0]    REQ_WDATA,
    input  logic [NUM_REQ*BE_WIDTH-1:0] REQ_BE,
    output logic [NUM_REQ-1:0]          RSP_VALID,
    output logic [DBITS-1:0]            RSP_RDATA,
    output logic                        BUSY,
    output logic [ABITS-1:0]            BRAM_ADDR,
    output logic [DBITS-1:0]            BRAM_WDATA,
    output logic                        BRAM_REN,
    output logic                        BRAM_WEN,
    output logic [BE_WIDTH-1:0]         BRAM_BE,
    input  logic [DBITS-1:0]            BRAM_RDATA
);

    // Width of a requester index; NUM_REQ is at least 2 so this is at least 1.
    localparam int PW = $clog2(NUM_REQ);

    localparam logic [PW:0]          NUM_REQ_W = (PW+1)'(NUM_REQ);
    localparam logic [PW-1:0]        LAST_REQ  = PW'(NUM_REQ - 1);
    localparam logic [ABITS-1:0]     LAST_ADDR = {ABITS{1'b1}};
    localparam logic [NUM_REQ-1:0]   REQ_ONE   = NUM_REQ'(1);
    localparam logic [BE_WIDTH-1:0]  BE_ALL    = {BE_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    // Registered state and its next-state values
    state_e               state_q;
    state_e               state_d;
    logic [ABITS-1:0]     clr_cnt_q;
    logic [ABITS-1:0]     clr_cnt_d;
    logic [PW-1:0]        rr_ptr_q;
    logic [PW-1:0]        rr_ptr_d;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [NUM_REQ-1:0]   rsp_valid_d;

    // Arbitration results
    logic                 gnt_found_s;
    logic [PW-1:0]        gnt_idx_s;
    logic [PW:0]          cand_raw_s;
    logic [PW:0]          cand_s;

    // Per-requester views of the packed request buses
    logic [ABITS-1:0]     req_addr_a  [NUM_REQ];
    logic [DBITS-1:0]     req_wdata_a [NUM_REQ];
    logic [BE_WIDTH-1:0]  req_be_a    [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_addr_a[gi]  = REQ_ADDR[gi*ABITS +: ABITS];
        assign req_wdata_a[gi] = REQ_WDATA[gi*DBITS +: DBITS];
        assign req_be_a[gi]    = REQ_BE[gi*BE_WIDTH +: BE_WIDTH];
    end

    // Round-robin search: first valid requester at or above the pointer, wrapping.
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        cand_raw_s  = '0;
        cand_s      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_raw_s = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (cand_raw_s >= NUM_REQ_W) begin
                cand_s = cand_raw_s - NUM_REQ_W;
            end else begin
                cand_s = cand_raw_s;
            end
            if (!gnt_found_s && REQ_VALID[cand_s[PW-1:0]]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = cand_s[PW-1:0];
            end else begin
                // an earlier candidate in the search order keeps the grant
            end
        end
    end

    // Next-state logic and BRAM port drive for the clear and run phases.
    // Nothing is granted or written while RST is high so a reset cycle is
    // never mistaken for a transfer by a requester.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = '0;
        REQ_READY   = '0;
        BRAM_ADDR   = '0;
        BRAM_WDATA  = '0;
        BRAM_BE     = '0;
        BRAM_REN    = 1'b0;
        BRAM_WEN    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                BRAM_ADDR = clr_cnt_q;
                BRAM_BE   = BE_ALL;
                BRAM_WEN  = ~RST;
                if (clr_cnt_q == LAST_ADDR) begin
                    // last word is written this cycle; the counter parks here
                    state_d = ST_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + ABITS'(1);
                end
            end
            ST_RUN: begin
                if (gnt_found_s && !RST) begin
                    REQ_READY  = REQ_ONE << gnt_idx_s;
                    BRAM_ADDR  = req_addr_a[gnt_idx_s];
                    BRAM_WDATA = req_wdata_a[gnt_idx_s];
                    BRAM_WEN   = REQ_WE[gnt_idx_s];
                    BRAM_REN   = ~REQ_WE[gnt_idx_s];
                    BRAM_BE    = REQ_WE[gnt_idx_s] ? req_be_a[gnt_idx_s] : BE_ALL;
                    rsp_valid_d = REQ_WE[gnt_idx_s] ? '0 : (REQ_ONE << gnt_idx_s);
                    rr_ptr_d   = (gnt_idx_s == LAST_REQ) ? '0 : (gnt_idx_s + PW'(1));
                end else begin
                    rr_ptr_d = rr_ptr_q;
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // State, clear counter, round-robin pointer and response flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= RESET_STATE;
            clr_cnt_q   <= '0;
            rr_ptr_q    <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // A response launched just before a reset is dropped as soon as RST rises.
    assign RSP_VALID = rsp_valid_q & {NUM_REQ{~RST}};
    assign RSP_RDATA = BRAM_RDATA;
    assign BUSY      = (state_q == ST_CLEAR);

endmodule
